// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round sequencer and its W schedule.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_H,
    LOAD_M,
    RND_CALC,
    RND_FB,
    READ
  } state_t;

  localparam logic [3:0] IDLE_ADDR = 4'hE;
  localparam logic [3:0] FB_ADDR   = 4'hF;

  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Message-schedule sigmas: rotations written as fixed concatenations.
  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_w_schedule.sv
// Sliding 16-word W window: loads M0..M15, then expands one new word per round.
module sha256_w_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_in,
  input  logic [31:0] shift_data,
  input  logic        advance,
  output logic [31:0] w_out
);

  // win[0] is W_t (oldest), win[15] is W_t+15
  logic [31:0] win [16];
  logic [31:0] w_next;

  assign w_next = s1(win[14]) + win[9] + s0(win[1]) + win[0];
  assign w_out  = win[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (shift_in || advance) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
      win[15] <= shift_in ? shift_data : w_next;
    end
  end

endmodule

// File: rtl/sha256_round_sequencer.sv
// Control sequencer for the SHA-256 round datapath: load H and M, run rounds, stream result.
// Build option SHA256_FINAL_ADD_EN adds the initial hash words to the output (true digest).
module sha256_round_sequencer
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  input  logic        init_valid,
  output logic        init_ready,
  input  logic [31:0] init_data,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_data,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [31:0] dout_data,
  output logic        dout_last,
  output logic [31:0] mb_in_var,
  output logic [31:0] mb_in_w,
  output logic [5:0]  mb_k_num,
  output logic [3:0]  mb_mem_in_addr,
  output logic [3:0]  mb_mem_out_addr,
  output logic        mb_en_mem_out,
  input  logic [31:0] mb_out_var
);

  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

  state_t      state;
  logic [2:0]  h_idx;
  logic [3:0]  m_idx;
  logic [5:0]  rnd;
  logic [2:0]  o_idx;
  logic        init_hs;
  logic        msg_hs;
  logic        dout_hs;
  logic        w_advance;
  logic [31:0] w_out;
  logic [31:0] final_word;

  assign init_hs   = init_valid & init_ready;
  assign msg_hs    = msg_valid & msg_ready;
  assign dout_hs   = dout_valid & dout_ready;
  assign w_advance = (state == RND_FB);

  sha256_w_schedule u_w_schedule (
    .clk        (clk),
    .rst        (rst),
    .shift_in   (msg_hs),
    .shift_data (msg_data),
    .advance    (w_advance),
    .w_out      (w_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      h_idx         <= '0;
      m_idx         <= '0;
      rnd           <= '0;
      o_idx         <= '0;
      busy          <= 1'b0;
      init_ready    <= 1'b0;
      msg_ready     <= 1'b0;
      dout_valid    <= 1'b0;
      mb_en_mem_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state      <= LOAD_H;
          busy       <= 1'b1;
          init_ready <= 1'b1;
        end
        LOAD_H: if (init_hs) begin
          h_idx <= h_idx + 3'd1;
          if (h_idx == 3'd7) begin
            state      <= LOAD_M;
            init_ready <= 1'b0;
            msg_ready  <= 1'b1;
          end
        end
        LOAD_M: if (msg_hs) begin
          m_idx <= m_idx + 4'd1;
          if (m_idx == 4'd15) begin
            state         <= RND_CALC;
            msg_ready     <= 1'b0;
            mb_en_mem_out <= 1'b1;
            rnd           <= '0;
          end
        end
        RND_CALC: begin
          state         <= RND_FB;
          mb_en_mem_out <= 1'b0;
        end
        RND_FB: begin
          if (rnd == LAST_RND) begin
            state      <= READ;
            rnd        <= '0;
            o_idx      <= '0;
            dout_valid <= 1'b1;
          end else begin
            state         <= RND_CALC;
            rnd           <= rnd + 6'd1;
            mb_en_mem_out <= 1'b1;
          end
        end
        READ: if (dout_hs) begin
          o_idx <= o_idx + 3'd1;
          if (o_idx == 3'd7) begin
            state      <= IDLE;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHA256_FINAL_ADD_EN
  logic [31:0] hreg [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) hreg[i] <= '0;
    end else if (init_hs) begin
      hreg[h_idx] <= init_data;
    end
  end

  assign final_word = mb_out_var + hreg[o_idx];
`else
  assign final_word = mb_out_var;
`endif

  // Load address follows the live handshake so the datapath writes in the accept cycle.
  always_comb begin
    mb_mem_in_addr = IDLE_ADDR;
    mb_in_var      = '0;
    if (state == LOAD_H && init_hs) begin
      mb_mem_in_addr = {1'b0, h_idx};
      mb_in_var      = init_data;
    end else if (state == RND_FB) begin
      mb_mem_in_addr = FB_ADDR;
    end
  end

  assign mb_in_w         = (state == RND_CALC) ? w_out : '0;
  assign mb_k_num        = rnd;
  assign mb_mem_out_addr = {1'b0, o_idx};
  assign dout_data       = dout_valid ? final_word : '0;
  assign dout_last       = dout_valid && (o_idx == 3'd7);

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Bench for sha256_round_sequencer: behavioural round datapath plus a plain SHA-256 reference.
module tb_sha256_round_sequencer;
  import sha256_pkg::*;

  typedef logic [7:0][31:0]  w8_t;
  typedef logic [15:0][31:0] w16_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] ABC_DIGEST [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  logic        clk = 1'b0;
  logic        rst, start, busy;
  logic        init_valid, init_ready, msg_valid, msg_ready;
  logic [31:0] init_data, msg_data;
  logic        dout_valid, dout_ready, dout_last;
  logic [31:0] dout_data;
  logic [31:0] mb_in_var, mb_in_w, mb_out_var;
  logic [5:0]  mb_k_num;
  logic [3:0]  mb_mem_in_addr, mb_mem_out_addr;
  logic        mb_en_mem_out;

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;
  int start_cyc = 0;

  w8_t         cur_h, cur_exp;
  w16_t        cur_m;
  logic [31:0] wexp [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_round_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .init_valid(init_valid), .init_ready(init_ready), .init_data(init_data),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last),
    .mb_in_var(mb_in_var), .mb_in_w(mb_in_w), .mb_k_num(mb_k_num),
    .mb_mem_in_addr(mb_mem_in_addr), .mb_mem_out_addr(mb_mem_out_addr),
    .mb_en_mem_out(mb_en_mem_out), .mb_out_var(mb_out_var)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One compression round on working variables a..h (index 0..7).
  function automatic w8_t sha_round(input w8_t v, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] t1, t2;
    w8_t r;
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w;
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    r[0] = t1 + t2; r[1] = v[0]; r[2] = v[1]; r[3] = v[2];
    r[4] = v[3] + t1; r[5] = v[4]; r[6] = v[5]; r[7] = v[6];
    return r;
  endfunction

  // Round datapath stand-in: register file A..H, output buffer, feedback capture.
  w8_t dp_reg, dp_buf;
  always @(posedge clk) begin
    if (mb_mem_in_addr < 4'd8) dp_reg[mb_mem_in_addr[2:0]] <= mb_in_var;
    else if (mb_mem_in_addr == 4'hF) dp_reg <= dp_buf;
    if (mb_en_mem_out) dp_buf <= sha_round(dp_reg, K[mb_k_num], mb_in_w);
  end
  assign mb_out_var = dp_buf[mb_mem_out_addr[2:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_ref();
    w8_t v;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) wexp[t] = cur_m[t];
      else wexp[t] = ssig1(wexp[t-2]) + wexp[t-7] + ssig0(wexp[t-15]) + wexp[t-16];
    end
    v = cur_h;
    for (int t = 0; t < 64; t++) v = sha_round(v, K[t], wexp[t]);
    for (int i = 0; i < 8; i++) begin
`ifdef SHA256_FINAL_ADD_EN
      cur_exp[i] = v[i] + cur_h[i];
`else
      cur_exp[i] = v[i];
`endif
    end
  endtask

  task automatic randomize_block();
    for (int i = 0; i < 8; i++) cur_h[i] = $urandom;
    for (int j = 0; j < 16; j++) cur_m[j] = $urandom;
    build_ref();
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_init_ready", 32'(init_ready), 32'd0);
    check("rst_msg_ready", 32'(msg_ready), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout_last", 32'(dout_last), 32'd0);
    check("rst_en_mem_out", 32'(mb_en_mem_out), 32'd0);
    check("rst_mem_in_addr", 32'(mb_mem_in_addr), 32'hE);
    check("rst_mem_out_addr", 32'(mb_mem_out_addr), 32'd0);
    check("rst_k_num", 32'(mb_k_num), 32'd0);
    check("rst_in_w", mb_in_w, 32'd0);
    check("rst_dout_data", dout_data, 32'd0);
  endtask

  task automatic load_h(input bit stall, input bit trace);
    int i = 0;
    int g = 0;
    bit hs;
    while (i < 8 && g < 200) begin
      init_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      init_data  = init_valid ? cur_h[i] : $urandom;
      @(negedge clk);
      check("h_init_ready", 32'(init_ready), 32'd1);
      hs = init_valid && init_ready;
      if (init_valid) begin
        check("h_addr", 32'(mb_mem_in_addr), 32'(i));
        check("h_in_var", mb_in_var, cur_h[i]);
        if (trace) check("h_cycle", 32'(cyc - start_cyc), 32'(i + 1));
      end else begin
        check("h_idle_addr", 32'(mb_mem_in_addr), 32'hE);
      end
      @(posedge clk); #1;
      g++;
      if (hs) i++;
    end
    init_valid = 1'b0;
    check("h_words_loaded", 32'(i), 32'd8);
  endtask

  task automatic load_m(input bit stall, input bit trace);
    int j = 0;
    int g = 0;
    bit hs;
    while (j < 16 && g < 300) begin
      msg_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      msg_data  = msg_valid ? cur_m[j] : $urandom;
      @(negedge clk);
      check("m_msg_ready", 32'(msg_ready), 32'd1);
      check("m_addr_idle", 32'(mb_mem_in_addr), 32'hE);
      hs = msg_valid && msg_ready;
      if (hs && trace) check("m_cycle", 32'(cyc - start_cyc), 32'(j + 9));
      @(posedge clk); #1;
      g++;
      if (hs) j++;
    end
    msg_valid = 1'b0;
    check("m_words_loaded", 32'(j), 32'd16);
  endtask

  task automatic run_rounds(input bit trace, input int pulse_rnd, input int rst_rnd, output bit aborted);
    int r = 0;
    int g = 0;
    bit fire_pulse = 0;
    bit fire_rst = 0;
    aborted = 0;
    while (g < 400) begin
      @(negedge clk);
      if (dout_valid) break;
      check("rnd_busy", 32'(busy), 32'd1);
      if (mb_en_mem_out) begin
        check("rnd_k_num", 32'(mb_k_num), 32'(r));
        if (r < 64) check("rnd_w", mb_in_w, wexp[r]);
        check("rnd_calc_addr", 32'(mb_mem_in_addr), 32'hE);
        if (trace) check("rnd_calc_cycle", 32'(cyc - start_cyc), 32'(25 + 2 * r));
        if (r == pulse_rnd) fire_pulse = 1;
      end else begin
        check("rnd_fb_addr", 32'(mb_mem_in_addr), 32'hF);
        if (trace) check("rnd_fb_cycle", 32'(cyc - start_cyc), 32'(26 + 2 * r));
        if (r == rst_rnd) fire_rst = 1;
        r++;
      end
      @(posedge clk); #1;
      g++;
      start = fire_pulse;
      fire_pulse = 0;
      if (fire_rst) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        aborted = 1;
        return;
      end
    end
    start = 1'b0;
    check("rounds_dout_valid", 32'(dout_valid), 32'd1);
    check("rounds_count", 32'(r), 32'd64);
    if (trace) check("first_dout_cycle", 32'(cyc - start_cyc), 32'd153);
    @(posedge clk); #1;
  endtask

  task automatic read_out(input bit stall);
    int i = 0;
    int g = 0;
    bit hs;
    bit prev_held = 0;
    logic [31:0] prev = '0;
    while (i < 8 && g < 300) begin
      dout_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      check("rd_dout_valid", 32'(dout_valid), 32'd1);
      check("rd_dout_data", dout_data, cur_exp[i]);
      check("rd_dout_last", 32'(dout_last), 32'(i == 7));
      check("rd_out_addr", 32'(mb_mem_out_addr), 32'(i));
      if (prev_held) check("rd_data_stable", dout_data, prev);
      hs = dout_valid && dout_ready;
      prev_held = !hs;
      prev = dout_data;
      @(posedge clk); #1;
      g++;
      if (hs) i++;
    end
    dout_ready = 1'b0;
    check("rd_words_read", 32'(i), 32'd8);
    @(negedge clk);
    check("rd_done_busy", 32'(busy), 32'd0);
    check("rd_done_valid", 32'(dout_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_block(input bit stall, input bit trace, input int pulse_rnd, input int rst_rnd);
    bit aborted;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    load_h(stall, trace);
    load_m(stall, trace);
    run_rounds(trace, pulse_rnd, rst_rnd, aborted);
    if (!aborted) read_out(stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    init_valid = 1'b0; init_data = '0;
    msg_valid = 1'b0; msg_data = '0;
    dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Standard IV with the padded "abc" block, strict port trace, no stalls.
    for (int i = 0; i < 8; i++) cur_h[i] = SHA256_IV[i];
    cur_m = '0;
    cur_m[0]  = 32'h61626380;
    cur_m[15] = 32'h00000018;
    build_ref();
    for (int i = 0; i < 8; i++) begin
`ifdef SHA256_FINAL_ADD_EN
      cur_exp[i] = ABC_DIGEST[i];
`else
      cur_exp[i] = ABC_DIGEST[i] - SHA256_IV[i];
`endif
    end
    run_block(1'b0, 1'b1, -1, -1);

    // Random block with random backpressure on all three streams.
    randomize_block();
    run_block(1'b1, 1'b0, -1, -1);

    // Random block with a stray start pulse mid-rounds.
    randomize_block();
    run_block(1'b0, 1'b0, 10, -1);

    // Reset during round 30, then a fresh random block with stalls.
    randomize_block();
    run_block(1'b0, 1'b0, -1, 30);
    randomize_block();
    run_block(1'b1, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
